// File: rtl/cpu_nios2_gen2_0_cpu_div_pkg.sv
// Shared types and constants for the iterative divider cell.
package cpu_nios2_gen2_0_cpu_div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 5;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Magnitude of an operand; unsigned operands pass through untouched.
  function automatic logic [DIV_W-1:0] div_abs(input logic [DIV_W-1:0] v,
                                               input logic             is_signed);
    return (is_signed && v[DIV_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/cpu_nios2_gen2_0_cpu_div_cell_if.sv
// Issue/result bundle between the E stage and the divider cell.
interface cpu_nios2_gen2_0_cpu_div_cell_if
  import cpu_nios2_gen2_0_cpu_div_pkg::*;
  ();

  logic             E_div_start;
  logic             E_div_signed;
  logic             E_div_kill;
  logic [DIV_W-1:0] E_src1;
  logic [DIV_W-1:0] E_src2;
  logic             M_div_busy;
  logic             M_div_done;
  logic [DIV_W-1:0] M_div_quot;
  logic [DIV_W-1:0] M_div_rem;
  logic             M_div_by_zero;

  // Pipeline side: issues operations, observes results.
  modport master (
    output E_div_start, E_div_signed, E_div_kill, E_src1, E_src2,
    input  M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_by_zero
  );

  // Divider side.
  modport slave (
    input  E_div_start, E_div_signed, E_div_kill, E_src1, E_src2,
    output M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_by_zero
  );

endinterface

// File: rtl/cpu_nios2_gen2_0_cpu_div_step.sv
// One radix-2 restoring division step, purely combinational.
module cpu_nios2_gen2_0_cpu_div_step
  import cpu_nios2_gen2_0_cpu_div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic             dvd_msb,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic             q_bit
);

  logic [DIV_W:0] shifted;

  // Shift in the next dividend bit and subtract when the divisor fits.
  // The difference always fits in DIV_W bits when it is taken, so only the
  // low bits of the subtraction are needed; a zero divisor always "fits",
  // which walks the whole dividend into the remainder.
  always_comb begin
    shifted = {rem_in, dvd_msb};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted[DIV_W-1:0] - divisor) : shifted[DIV_W-1:0];
  end

endmodule

// File: rtl/cpu_nios2_gen2_0_cpu_div_cell.sv
// Iterative 32-bit divider for div/divu: capture, 32 restoring steps,
// one sign-fix cycle. Results are registered and held until the next done.
//
// state | meaning
// IDLE  | waiting for a start; outputs hold the last result
// RUN   | one restoring step per cycle, 32 cycles
// FIX   | sign correction, result register load, done pulse
module cpu_nios2_gen2_0_cpu_div_cell
  import cpu_nios2_gen2_0_cpu_div_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset_n,
  cpu_nios2_gen2_0_cpu_div_cell_if.slave  div_if
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] rem_q;
  logic [DIV_W-1:0] dvd_q;
  logic [DIV_W-1:0] dsr_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dz_q;

  logic             accept;
  logic             step_en;
  logic             fix_en;

  logic [DIV_W-1:0] step_rem;
  logic             step_qbit;

  logic             done_q;
  logic [DIV_W-1:0] quot_q;
  logic [DIV_W-1:0] rem_out_q;
  logic             by_zero_q;

  cpu_nios2_gen2_0_cpu_div_step u_step (
    .rem_in  (rem_q),
    .dvd_msb (dvd_q[DIV_W-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-cycle datapath enables; kill beats start and
  // aborts RUN/FIX without a done.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step_en = 1'b0;
    fix_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_if.E_div_start && !div_if.E_div_kill) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (div_if.E_div_kill) begin
          state_d = IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt_q == LAST_STEP) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!div_if.E_div_kill) fix_en = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and the iterating {rem, dividend/quotient} shift pair.
  // Quotient bits enter at the bottom of dvd_q as dividend bits leave the top,
  // so after the last step dvd_q holds the unsigned quotient.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= div_abs(div_if.E_src1, div_if.E_div_signed);
      dsr_q   <= div_abs(div_if.E_src2, div_if.E_div_signed);
      q_neg_q <= div_if.E_div_signed & (div_if.E_src1[DIV_W-1] ^ div_if.E_src2[DIV_W-1]);
      r_neg_q <= div_if.E_div_signed & div_if.E_src1[DIV_W-1];
      dz_q    <= (div_if.E_src2 == '0);
    end else if (step_en) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      rem_q   <= step_rem;
      dvd_q   <= {dvd_q[DIV_W-2:0], step_qbit};
    end
  end

  // Result registers and done pulse. On divide-by-zero the quotient keeps
  // the all-ones pattern; the remainder holds |src1|, and re-applying the
  // dividend sign hands back src1 exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_out_q <= '0;
      by_zero_q <= 1'b0;
    end else begin
      done_q <= fix_en;
      if (fix_en) begin
        quot_q    <= (q_neg_q && !dz_q) ? -dvd_q : dvd_q;
        rem_out_q <= r_neg_q ? -rem_q : rem_q;
        by_zero_q <= dz_q;
      end
    end
  end

  assign div_if.M_div_busy    = (state_q != IDLE);
  assign div_if.M_div_done    = done_q;
  assign div_if.M_div_quot    = quot_q;
  assign div_if.M_div_rem     = rem_out_q;
  assign div_if.M_div_by_zero = by_zero_q;

endmodule
